// File: rtl/ibuffer_pkg.sv
// ibuffer_pkg: shared field widths and the stored instruction-buffer entry.
package ibuffer_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 48;
  localparam int TGT_W = 32;
  typedef struct packed {
    logic [INSTR_W-1:0] inst;
    logic [PC_W-1:0]    pc;
    logic               taken;
    logic [TGT_W-1:0]   target;
  } entry_t;
endpackage

// File: rtl/ibuffer.sv
// ibuffer: circular FIFO between fetch and decode with one-cycle flush.
module ibuffer
  import ibuffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               ifu_instr_valid,
  output logic               ifu_instr_ready,
  input  logic [INSTR_W-1:0] ifu_inst,
  input  logic [PC_W-1:0]    ifu_pc,
  input  logic               ifu_predicttaken,
  input  logic [TGT_W-1:0]   ifu_predicttarget,
  input  logic               ibuffer_read_en,
  input  logic               flush_valid,
  output logic               fifo_empty,
  output logic               ibuffer_instr_valid,
  output logic [INSTR_W-1:0] ibuffer_inst_out,
  output logic [PC_W-1:0]    ibuffer_pc_out,
  output logic               ibuffer_predicttaken_out,
  output logic [TGT_W-1:0]   ibuffer_predicttarget_out,
  output logic [PTR_W:0]     ibuffer_count
);
  entry_t mem [DEPTH];
  entry_t head;
  logic [PTR_W:0] wptr, rptr;
  logic full, push, pop;
  // Wrap bit disambiguates full from empty when the index bits match
  assign full = (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]) && (wptr[PTR_W] != rptr[PTR_W]);
  assign fifo_empty = wptr == rptr;
  assign ifu_instr_ready = !full;
  assign ibuffer_instr_valid = !fifo_empty;
  assign ibuffer_count = wptr - rptr;
  assign push = ifu_instr_valid && !full && !flush_valid;
  assign pop = ibuffer_read_en && !fifo_empty && !flush_valid;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush_valid) begin
      rptr <= wptr;
    end else begin
      if (push) wptr <= wptr + (PTR_W+1)'(1);
      if (pop) rptr <= rptr + (PTR_W+1)'(1);
    end
  always_ff @(posedge clock)
    if (push) mem[wptr[PTR_W-1:0]] <= {ifu_inst, ifu_pc, ifu_predicttaken, ifu_predicttarget};
  assign head = fifo_empty ? '0 : mem[rptr[PTR_W-1:0]];
  assign ibuffer_inst_out = head.inst;
  assign ibuffer_pc_out = head.pc;
  assign ibuffer_predicttaken_out = head.taken;
  assign ibuffer_predicttarget_out = head.target;
endmodule

// File: tb/tb_ibuffer.sv
// tb_ibuffer: table-driven, directed and random checks against a queue model.
module tb_ibuffer;
  import ibuffer_pkg::*;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  logic clock = 0, reset_n = 0;
  logic ifu_instr_valid = 0, ibuffer_read_en = 0, flush_valid = 0;
  logic ifu_instr_ready, fifo_empty, ibuffer_instr_valid, ibuffer_predicttaken_out;
  logic ifu_predicttaken = 0;
  logic [31:0] ifu_inst = 0, ifu_predicttarget = 0, ibuffer_inst_out, ibuffer_predicttarget_out;
  logic [47:0] ifu_pc = 0, ibuffer_pc_out;
  logic [PTR_W:0] ibuffer_count;
  int errors = 0, checks = 0;
  entry_t q[$];
  entry_t zero_e = '0;

  ibuffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .ifu_instr_valid(ifu_instr_valid), .ifu_instr_ready(ifu_instr_ready),
    .ifu_inst(ifu_inst), .ifu_pc(ifu_pc), .ifu_predicttaken(ifu_predicttaken),
    .ifu_predicttarget(ifu_predicttarget), .ibuffer_read_en(ibuffer_read_en),
    .flush_valid(flush_valid), .fifo_empty(fifo_empty),
    .ibuffer_instr_valid(ibuffer_instr_valid), .ibuffer_inst_out(ibuffer_inst_out),
    .ibuffer_pc_out(ibuffer_pc_out), .ibuffer_predicttaken_out(ibuffer_predicttaken_out),
    .ibuffer_predicttarget_out(ibuffer_predicttarget_out), .ibuffer_count(ibuffer_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic v, rd, fl;
    int exp_count;
    logic exp_ready, exp_empty;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    entry_t h;
    h = (q.size() > 0) ? q[0] : zero_e;
    chk({tag, " empty"}, 64'(fifo_empty), 64'(q.size() == 0));
    chk({tag, " valid"}, 64'(ibuffer_instr_valid), 64'(q.size() != 0));
    chk({tag, " ready"}, 64'(ifu_instr_ready), 64'(q.size() < DEPTH));
    chk({tag, " count"}, 64'(ibuffer_count), 64'(q.size()));
    chk({tag, " inst"}, 64'(ibuffer_inst_out), 64'(h.inst));
    chk({tag, " pc"}, 64'(ibuffer_pc_out), 64'(h.pc));
    chk({tag, " taken"}, 64'(ibuffer_predicttaken_out), 64'(h.taken));
    chk({tag, " target"}, 64'(ibuffer_predicttarget_out), 64'(h.target));
  endtask

  // One clock: drive, confirm outputs still reflect pre-edge state, advance model, recheck.
  task automatic step(input logic v, input logic rd, input logic fl, input entry_t e, input string tag);
    bit do_push, do_pop;
    ifu_instr_valid = v; ibuffer_read_en = rd; flush_valid = fl;
    ifu_inst = e.inst; ifu_pc = e.pc; ifu_predicttaken = e.taken; ifu_predicttarget = e.target;
    #1;
    check_outputs({tag, " pre"});
    do_push = v && q.size() < DEPTH && !fl;
    do_pop = rd && q.size() > 0 && !fl;
    @(posedge clock);
    #1;
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    check_outputs({tag, " post"});
  endtask

  function automatic entry_t rnd_entry();
    entry_t e;
    e.inst = $urandom;
    e.pc = {16'($urandom), 32'($urandom)};
    e.taken = 1'($urandom);
    e.target = $urandom;
    return e;
  endfunction

  initial begin
    entry_t e;
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, (i < 8) ? i + 1 : 8, i < 7, 1'b0};
    tbl[8].exp_count = 8;
    tbl[9] = '{1'b1, 1'b1, 1'b0, 7, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 6, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};

    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    check_outputs("reset");
    e = '{inst: 32'h00A00093, pc: 48'h80000000, taken: 1'b1, target: 32'h80000010};
    step(1, 0, 0, e, "single");
    chk("single inst", 64'(ibuffer_inst_out), 64'h00A00093);
    chk("single pc", 64'(ibuffer_pc_out), 64'h80000000);
    chk("single target", 64'(ibuffer_predicttarget_out), 64'h80000010);
    chk("single count", 64'(ibuffer_count), 64'd1);
    step(0, 1, 0, zero_e, "drain");

    for (int i = 0; i < 15; i++) begin
      e = '{inst: 32'h1000 + 32'(i), pc: 48'h4000 + 48'(4 * i), taken: 1'(i), target: 32'hA000 + 32'(i)};
      step(tbl[i].v, tbl[i].rd, tbl[i].fl, e, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d count", i), 64'(ibuffer_count), 64'(tbl[i].exp_count));
      chk($sformatf("vec%0d ready", i), 64'(ifu_instr_ready), 64'(tbl[i].exp_ready));
      chk($sformatf("vec%0d empty", i), 64'(fifo_empty), 64'(tbl[i].exp_empty));
    end
    chk("after flush head pc", 64'(ibuffer_pc_out), 64'h4000 + 64'(4 * 14));

    for (int i = 0; i < 20; i++) begin
      e = '{inst: 32'hC0DE0000 + 32'(i), pc: 48'h80000100 + 48'(4 * i), taken: 1'b0, target: 32'(i)};
      step(1, 1, 0, e, "stream");
      chk("stream count", 64'(ibuffer_count), 64'd1);
    end

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0), rnd_entry(), "rand");
    end

    step(0, 0, 1, zero_e, "preflush");
    for (int i = 0; i < 3; i++) step(1, 0, 0, rnd_entry(), "prefill");
    chk("prefill count", 64'(ibuffer_count), 64'd3);
    ifu_instr_valid = 0;
    @(negedge clock);
    #1 reset_n = 0;
    #1;
    q.delete();
    check_outputs("async reset");
    chk("async reset count", 64'(ibuffer_count), 64'd0);
    chk("async reset empty", 64'(fifo_empty), 64'd1);
    @(posedge clock);
    #1 reset_n = 1;
    step(1, 0, 0, rnd_entry(), "post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ibuffer.md
# ibuffer

Instruction buffer between the fetch unit (IFU) and the decode stage (IDU). It accepts one fetched instruction per cycle with its PC and branch-prediction info and stores it in a circular FIFO. The head entry is presented to the IDU, which pops it with `ibuffer_read_en`. A backend flush empties the buffer in one cycle.

## Interface
- `DEPTH`, 8: number of entries; a power of two, at least 2.
- `PTR_W`, `$clog2(DEPTH)`: index width; pointers are `PTR_W+1` bits wide, including a wrap bit.

- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ifu_instr_valid`  in  1  IFU presents an instruction.
- `ifu_instr_ready`  out  1  the buffer can accept an instruction this cycle.
- `ifu_inst`  in  32  instruction word.
- `ifu_pc`  in  48  instruction PC.
- `ifu_predicttaken`  in  1  BPU taken prediction.
- `ifu_predicttarget`  in  32  BPU predicted target.
- `ibuffer_read_en`  in  1  pop request from the IDU.
- `flush_valid`  in  1  flush from intwb.
- `fifo_empty`  out  1  the buffer holds no entries.
- `ibuffer_instr_valid`  out  1  the head entry is valid; always equal to `!fifo_empty`.
- `ibuffer_inst_out`  out  32  head instruction.
- `ibuffer_pc_out`  out  48  head PC.
- `ibuffer_predicttaken_out`  out  1  head taken prediction.
- `ibuffer_predicttarget_out`  out  32  head predicted target.
- `ibuffer_count`  out  `PTR_W+1`  occupancy, for perf counters.

## Operation
- **Storage:** an array of `DEPTH` entries, each holding {inst, pc, predicttaken, predicttarget}.
- **Pointers:** write pointer `wptr` and read pointer `rptr`, each `PTR_W+1` bits.
  - Empty when `wptr == rptr`.
  - Full when the index bits are equal and the wrap bits differ.
  - The count is `wptr - rptr`, computed modulo 2^(PTR_W+1).
- **Ready:** `ifu_instr_ready = !full`. It depends only on registered state. There is no combinational path from `ibuffer_read_en`, so a pop in the same cycle does not make a full buffer ready.
- **Enqueue:** when `ifu_instr_valid && ifu_instr_ready && !flush_valid`, write the entry at `wptr[PTR_W-1:0]` and increment `wptr`.
- **Dequeue:** when `ibuffer_read_en && !fifo_empty && !flush_valid`, increment `rptr`. A pop request while empty is ignored and causes no pointer movement.
- **Simultaneous enqueue and dequeue** on a non-full, non-empty buffer: both pointers advance and the count is unchanged.
- **Flush:** `rptr <= wptr`, so the buffer is empty on the next cycle. Flush has priority: an enqueue or dequeue in the flush cycle is discarded. The IFU is responsible for deasserting valid or refetching after the flush.
- **Head outputs:** combinational reads of entry `rptr[PTR_W-1:0]`, gated to zero when empty.
- **Wrap-around:** the index bits roll over from `DEPTH-1` to 0 and the wrap bit toggles. No other special case.
- **No bypass:** an entry written while the buffer is empty is not visible in the same cycle.

## Timing
- **Reset values:** `wptr = rptr = 0`, so:
  - `fifo_empty = 1`
  - `ibuffer_instr_valid = 0`
  - all head data outputs = 0
  - `ifu_instr_ready = 1`
  - `ibuffer_count = 0`
- Storage contents need no reset.
- **Latency:** an enqueue at edge N is visible on the head outputs after edge N (cycle N+1).
- **Throughput:** one enqueue and one dequeue per cycle, sustained.
- `ibuffer_read_en` is sampled at the edge. The head outputs show the next entry in the following cycle.
- **Flush:** asserted in cycle N, `fifo_empty = 1` in cycle N+1. A new enqueue is accepted in cycle N+1.
- **Reset mid-operation:** everything returns to the reset values immediately (asynchronous reset). In-flight entries are lost.

## Structure
- The field widths (PC 48, instruction 32, prediction target 32) come from the shared defines package. Examples: `PC_RANGE`, `INSTR_RANGE`. No new package types are needed.
- Single module with no sub-module. The pointer/count logic and the storage array stay inline; the block is roughly 150 RTL lines.

## Test plan
- **Reset and single entry:** after reset, check the empty state. Enqueue inst `0x00A00093`, pc `0x80000000`, taken 1, target `0x80000010`. In the next cycle the head shows those values, valid = 1, count = 1.
- **Fill to full:** enqueue 8 entries with no pops. `ifu_instr_ready = 0` and count = 8. A ninth valid is not accepted. Assert `read_en` while full: ready returns only in the cycle after the pop.
- **Streaming with wrap:** hold valid and `read_en` for 20 cycles with PCs incrementing by 4. Output order is exact, count stays constant, and the pointers wrap twice without any glitch.
- **Pop while empty:** assert `read_en` with the buffer empty. Pointers and count are unchanged; `fifo_empty` stays 1.
- **Flush priority:** with 5 entries, assert flush together with valid and `read_en`. In the next cycle the buffer is empty, count = 0, and the enqueued instruction is absent.
- **Mid-operation reset:** with 3 entries, drop `reset_n` asynchronously between edges. The outputs reach their reset values before the next edge.
